// File: rtl/rij_pkg.sv
// Shared encodings for the MultiSegCPU control path: opcodes, functs,
// ALU operations, controller states and datapath mux selects.
`timescale 1ns/1ps
package rij_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_NOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLTU = 3'b111;

  localparam logic [3:0] S_IF       = 4'd0;
  localparam logic [3:0] S_ID       = 4'd1;
  localparam logic [3:0] S_EXE_R    = 4'd2;
  localparam logic [3:0] S_EXE_I    = 4'd3;
  localparam logic [3:0] S_EXE_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_WB_R     = 4'd7;
  localparam logic [3:0] S_WB_I     = 4'd8;
  localparam logic [3:0] S_WB_LW    = 4'd9;
  localparam logic [3:0] S_BR       = 4'd10;
  localparam logic [3:0] S_JMP      = 4'd11;
  localparam logic [3:0] S_HALT     = 4'd15;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Instruction class chosen in ID; selects the first execute state.
  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_MEM = 3'd2,
    CLS_BR  = 3'd3,
    CLS_JMP = 3'd4,
    CLS_ILL = 3'd5
  } instr_class_t;

endpackage

// File: rtl/multi_seg_decode.sv
// Combinational instruction decoder: classifies opcode/funct and picks the
// ALU operation and whether signed overflow must block writeback.
`timescale 1ns/1ps
module multi_seg_decode
  import rij_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] cls,
  output logic [2:0] alu_op,
  output logic       ovf_chk,
  output logic       legal
);

  always_comb begin
    cls     = CLS_ILL;
    alu_op  = ALU_ADD;
    ovf_chk = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        cls = CLS_R;
        case (funct)
          FN_ADD:  begin alu_op = ALU_ADD; ovf_chk = 1'b1; end
          FN_SUB:  begin alu_op = ALU_SUB; ovf_chk = 1'b1; end
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          default: cls = CLS_ILL;
        endcase
      end
      OP_ADDI:  begin cls = CLS_I; alu_op = ALU_ADD; ovf_chk = 1'b1; end
      OP_ANDI:  begin cls = CLS_I; alu_op = ALU_AND;  end
      OP_ORI:   begin cls = CLS_I; alu_op = ALU_OR;   end
      OP_XORI:  begin cls = CLS_I; alu_op = ALU_XOR;  end
      OP_SLTIU: begin cls = CLS_I; alu_op = ALU_SLTU; end
      OP_LW, OP_SW:   cls = CLS_MEM;
      OP_BEQ, OP_BNE: begin cls = CLS_BR; alu_op = ALU_SUB; end
      OP_J, OP_JAL:   cls = CLS_JMP;
      default:        cls = CLS_ILL;
    endcase
  end

  assign legal = (cls != CLS_ILL);

endmodule

// File: rtl/multi_seg_ctrl.sv
// Multi-cycle controller for the MultiSegCPU datapath: sequences IF/ID/EX/
// MEM/WB, drives all enables and selects, counts retired instructions.
`timescale 1ns/1ps
module multi_seg_ctrl
  import rij_pkg::*;
#(
  parameter int   CNT_W       = 32,
  parameter logic MEM_WAIT_EN = 1'b1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             ZF,
  input  logic             OF,
  input  logic             mem_ready,
  output logic             PC_Write,
  output logic             IR_Write,
  output logic             Mem_Read,
  output logic             Mem_Write,
  output logic             IorD,
  output logic             Reg_Write,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemToReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALU_OP,
  output logic [1:0]       PCSrc,
  output logic             halt,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  logic [3:0] state_q;
  logic [3:0] state_next;
  logic       ovf_q;
  logic       retire;
  logic       mem_rdy;
  logic [2:0] dec_cls;
  logic [2:0] dec_alu_op;
  logic       dec_ovf_chk;
  logic       dec_legal;

  multi_seg_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .cls     (dec_cls),
    .alu_op  (dec_alu_op),
    .ovf_chk (dec_ovf_chk),
    .legal   (dec_legal)
  );

  assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_comb begin
    state_next = state_q;
    retire     = 1'b0;
    case (state_q)
      S_IF:       if (mem_rdy) state_next = S_ID;
      S_ID: begin
        if (!dec_legal) state_next = S_HALT;
        else begin
          case (dec_cls)
            CLS_R:   state_next = S_EXE_R;
            CLS_I:   state_next = S_EXE_I;
            CLS_MEM: state_next = S_EXE_ADDR;
            CLS_BR:  state_next = S_BR;
            CLS_JMP: state_next = S_JMP;
            default: state_next = S_HALT;
          endcase
        end
      end
      S_EXE_R:    state_next = S_WB_R;
      S_EXE_I:    state_next = S_WB_I;
      S_EXE_ADDR: state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_rdy) state_next = S_WB_LW;
      S_MEM_WR: begin
        if (mem_rdy) begin
          state_next = S_IF;
          retire     = 1'b1;
        end
      end
      S_WB_R, S_WB_I, S_WB_LW, S_BR, S_JMP: begin
        state_next = S_IF;
        retire     = 1'b1;
      end
      S_HALT:     state_next = S_HALT;
      // Unused encodings are treated like an illegal instruction.
      default:    state_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IF;
      ovf_q     <= 1'b0;
      instr_cnt <= '0;
    end else begin
      state_q <= state_next;
      if (state_q == S_EXE_R || state_q == S_EXE_I)
        ovf_q <= OF & dec_ovf_chk;
      if (retire)
        instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  // Outputs are forced low while rst is high so a write strobe drops at once.
  always_comb begin
    PC_Write  = 1'b0;
    IR_Write  = 1'b0;
    Mem_Read  = 1'b0;
    Mem_Write = 1'b0;
    IorD      = 1'b0;
    Reg_Write = 1'b0;
    RegDst    = DST_RT;
    MemToReg  = M2R_ALU;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RT;
    ALU_OP    = ALU_AND;
    PCSrc     = PC_ALU;
    if (!rst) begin
      case (state_q)
        S_IF: begin
          Mem_Read = 1'b1;
          ALUSrcB  = SRCB_FOUR;
          ALU_OP   = ALU_ADD;
          IR_Write = mem_rdy;
          PC_Write = mem_rdy;
        end
        S_ID: begin
          ALUSrcB = SRCB_BR;
          ALU_OP  = ALU_ADD;
        end
        S_EXE_R: begin
          ALUSrcA = 1'b1;
          ALU_OP  = dec_alu_op;
        end
        S_EXE_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          ALU_OP  = dec_alu_op;
        end
        S_EXE_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          ALU_OP  = ALU_ADD;
        end
        S_MEM_RD: begin
          IorD     = 1'b1;
          Mem_Read = 1'b1;
        end
        S_MEM_WR: begin
          IorD      = 1'b1;
          Mem_Write = 1'b1;
        end
        S_WB_R: begin
          RegDst    = DST_RD;
          Reg_Write = ~ovf_q;
        end
        S_WB_I:  Reg_Write = ~ovf_q;
        S_WB_LW: begin
          MemToReg  = M2R_MDR;
          Reg_Write = 1'b1;
        end
        S_BR: begin
          ALUSrcA  = 1'b1;
          ALU_OP   = ALU_SUB;
          PCSrc    = PC_ALUOUT;
          PC_Write = (opcode == OP_BEQ) ? ZF : ~ZF;
        end
        S_JMP: begin
          PCSrc    = PC_JUMP;
          PC_Write = 1'b1;
          if (opcode == OP_JAL) begin
            Reg_Write = 1'b1;
            RegDst    = DST_RA;
            MemToReg  = M2R_PC;
          end
        end
        default: ;
      endcase
    end
  end

  assign halt  = (state_q == S_HALT);
  assign state = state_q;

endmodule

// File: tb/tb_multi_seg_ctrl.sv
// Self-checking bench for multi_seg_ctrl: an instruction-level model expands
// each instruction into its expected per-cycle outputs.
`timescale 1ns/1ps
module tb_multi_seg_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        ZF = 1'b0;
  logic        OF = 1'b0;
  logic        mem_ready = 1'b0;
  logic        PC_Write, IR_Write, Mem_Read, Mem_Write, IorD, Reg_Write;
  logic [1:0]  RegDst, MemToReg, ALUSrcB, PCSrc;
  logic        ALUSrcA, halt;
  logic [2:0]  ALU_OP;
  logic [3:0]  state;
  logic [31:0] instr_cnt;

  multi_seg_ctrl #(.CNT_W(32), .MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .ZF(ZF), .OF(OF),
    .mem_ready(mem_ready), .PC_Write(PC_Write), .IR_Write(IR_Write),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .IorD(IorD),
    .Reg_Write(Reg_Write), .RegDst(RegDst), .MemToReg(MemToReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_OP(ALU_OP), .PCSrc(PCSrc),
    .halt(halt), .state(state), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, irw, mrd, mwr, iord, rw;
    logic [1:0] dst, m2r;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] alu;
    logic [1:0] pcsrc;
  } ctl_t;

  typedef struct {
    logic [3:0]  st;
    ctl_t        c;
    logic        hlt;
    logic [31:0] cnt;
    logic        rdy, zf, of;
  } cyc_t;

  ctl_t        dut_ctl;
  cyc_t        q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_cnt = '0;
  logic [31:0] trace;
  logic [7:0]  last_snap;
  string       cur_tag = "reset";

  logic [5:0] fn_tab [8]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
  logic [5:0] op_tab [13] = '{6'h00, 6'h00, 6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0b,
                              6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03};

  assign dut_ctl = {PC_Write, IR_Write, Mem_Read, Mem_Write, IorD, Reg_Write,
                    RegDst, MemToReg, ALUSrcA, ALUSrcB, ALU_OP, PCSrc};

  // 0 R-type, 1 immediate ALU, 2 lw, 3 sw, 4 branch, 5 jump, 6 illegal
  function automatic int kindOf(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        kindOf = 6;
        for (int i = 0; i < 8; i++) if (fn == fn_tab[i]) kindOf = 0;
      end
      6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0b: kindOf = 1;
      6'h23:        kindOf = 2;
      6'h2b:        kindOf = 3;
      6'h04, 6'h05: kindOf = 4;
      6'h02, 6'h03: kindOf = 5;
      default:      kindOf = 6;
    endcase
  endfunction

  function automatic logic [2:0] aluOf(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      case (fn)
        6'h20: aluOf = 3'd2;  6'h22: aluOf = 3'd6;
        6'h24: aluOf = 3'd0;  6'h25: aluOf = 3'd1;
        6'h26: aluOf = 3'd3;  6'h27: aluOf = 3'd4;
        6'h2a: aluOf = 3'd5;  default: aluOf = 3'd7;
      endcase
    end else begin
      case (op)
        6'h0c: aluOf = 3'd0;  6'h0d: aluOf = 3'd1;
        6'h0e: aluOf = 3'd3;  6'h0b: aluOf = 3'd7;
        default: aluOf = 3'd2;
      endcase
    end
  endfunction

  function automatic cyc_t blank(input logic [3:0] st);
    cyc_t r;
    r.st  = st;
    r.c   = '0;
    r.hlt = 1'b0;
    r.cnt = exp_cnt;
    r.rdy = 1'($urandom_range(0, 1));
    r.zf  = 1'($urandom_range(0, 1));
    r.of  = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s/%s: got 0x%0h, want 0x%0h", cur_tag, name, act, exp);
    end
  endtask

  // Expand one instruction into expected cycles, then drive and check them.
  task automatic applyStimulus(input string tag, input logic [5:0] op, input logic [5:0] fn,
                               input int ifw, input int memw, input logic zfb,
                               input logic ofe, input int abort_after);
    cyc_t r;
    int   kind, n;
    logic ovf_blocks;
    cur_tag = tag;
    kind = kindOf(op, fn);
    ovf_blocks = ofe && ((op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) || op == 6'h08);
    for (int w = 0; w <= ifw; w++) begin
      r = blank(4'd0);
      r.c.mrd = 1'b1; r.c.srcb = 2'b01; r.c.alu = 3'd2;
      r.rdy = (w == ifw);
      r.c.irw = r.rdy; r.c.pcw = r.rdy;
      q.push_back(r);
    end
    r = blank(4'd1); r.c.srcb = 2'b11; r.c.alu = 3'd2; q.push_back(r);
    case (kind)
      0, 1: begin
        r = blank(kind == 0 ? 4'd2 : 4'd3);
        r.c.srca = 1'b1; r.c.srcb = (kind == 0) ? 2'b00 : 2'b10;
        r.c.alu = aluOf(op, fn); r.of = ofe; q.push_back(r);
        r = blank(kind == 0 ? 4'd7 : 4'd8);
        r.c.dst = (kind == 0) ? 2'b01 : 2'b00; r.c.rw = !ovf_blocks; q.push_back(r);
      end
      2, 3: begin
        r = blank(4'd4); r.c.srca = 1'b1; r.c.srcb = 2'b10; r.c.alu = 3'd2; q.push_back(r);
        for (int w = 0; w <= memw; w++) begin
          r = blank(kind == 2 ? 4'd5 : 4'd6);
          r.c.iord = 1'b1; r.c.mrd = (kind == 2); r.c.mwr = (kind == 3);
          r.rdy = (w == memw); q.push_back(r);
        end
        if (kind == 2) begin
          r = blank(4'd9); r.c.m2r = 2'b01; r.c.rw = 1'b1; q.push_back(r);
        end
      end
      4: begin
        r = blank(4'd10); r.c.srca = 1'b1; r.c.alu = 3'd6; r.c.pcsrc = 2'b01;
        r.zf = zfb; r.c.pcw = (op == 6'h04) ? zfb : !zfb; q.push_back(r);
      end
      5: begin
        r = blank(4'd11); r.c.pcsrc = 2'b10; r.c.pcw = 1'b1;
        if (op == 6'h03) begin r.c.rw = 1'b1; r.c.dst = 2'b10; r.c.m2r = 2'b10; end
        q.push_back(r);
      end
      default: begin
        for (int i = 0; i < 20; i++) begin
          r = blank(4'd15); r.hlt = 1'b1; q.push_back(r);
        end
      end
    endcase
    if (kind != 6) exp_cnt = exp_cnt + 1;
    trace = '0;
    n = 0;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(posedge clk); #1;
      opcode = op; funct = fn; mem_ready = r.rdy; ZF = r.zf; OF = r.of;
      @(negedge clk);
      checkOutput("state", 32'(state), 32'(r.st));
      checkOutput("ctrl", 32'(dut_ctl), 32'(r.c));
      checkOutput("halt", 32'(halt), 32'(r.hlt));
      checkOutput("instr_cnt", instr_cnt, r.cnt);
      trace = {trace[27:0], state};
      last_snap = {PC_Write, PCSrc, Reg_Write, RegDst, MemToReg};
      n++;
      if (abort_after != 0 && n == abort_after) q.delete();
    end
  endtask

  task automatic settle(input string tag, input logic [31:0] want_cnt);
    cur_tag = tag;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("settle_state", 32'(state), 32'd0);
    checkOutput("settle_cnt", instr_cnt, want_cnt);
  endtask

  task automatic pulseReset(input string tag);
    ctl_t fetch;
    cur_tag = tag;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    fetch = '0; fetch.mrd = 1'b1; fetch.srcb = 2'b01; fetch.alu = 3'd2;
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_halt", 32'(halt), 32'd0);
    checkOutput("rst_cnt", instr_cnt, 32'd0);
    checkOutput("rst_ctrl", 32'(dut_ctl), 32'(fetch));
    exp_cnt = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [5:0] rop, rfn;
    repeat (2) @(negedge clk);
    checkOutput("in_rst_state", 32'(state), 32'd0);
    checkOutput("in_rst_ctrl", 32'(dut_ctl), 32'd0);
    checkOutput("in_rst_halt", 32'(halt), 32'd0);
    checkOutput("in_rst_cnt", instr_cnt, 32'd0);
    rst = 1'b0;

    applyStimulus("add", 6'h00, 6'h20, 0, 0, 1'b0, 1'b0, 0);
    checkOutput("add_trace", trace & 32'hFFFF, 32'h0127);
    settle("add", 32'd1);

    applyStimulus("lw", 6'h23, 6'h15, 0, 3, 1'b0, 1'b0, 0);
    checkOutput("lw_trace", trace, 32'h01455559);
    settle("lw", 32'd2);

    applyStimulus("beq", 6'h04, 6'h00, 0, 0, 1'b1, 1'b0, 0);
    checkOutput("beq_snap", 32'(last_snap), 32'hA0);
    applyStimulus("bne", 6'h05, 6'h00, 1, 0, 1'b1, 1'b0, 0);
    checkOutput("bne_snap", 32'(last_snap), 32'h20);
    settle("br", 32'd4);

    applyStimulus("jal", 6'h03, 6'h00, 0, 0, 1'b0, 1'b0, 0);
    checkOutput("jal_snap", 32'(last_snap), 32'hDA);
    settle("jal", 32'd5);

    applyStimulus("addi_ovf", 6'h08, 6'h00, 0, 0, 1'b0, 1'b1, 0);
    checkOutput("addi_snap", 32'(last_snap), 32'h00);
    settle("addi_ovf", 32'd6);

    applyStimulus("sw", 6'h2b, 6'h00, 2, 2, 1'b0, 1'b0, 0);
    settle("sw", 32'd7);

    for (int i = 0; i < 60; i++) begin
      rop = op_tab[$urandom_range(0, 12)];
      rfn = (rop == 6'h00) ? fn_tab[$urandom_range(0, 7)] : 6'($urandom);
      applyStimulus($sformatf("rand%0d", i), rop, rfn, $urandom_range(0, 2),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 0);
    end
    settle("rand_end", 32'd67);

    // sw interrupted by reset while Mem_Write is held
    applyStimulus("sw_abort", 6'h2b, 6'h00, 0, 4, 1'b0, 1'b0, 5);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort_mwr", 32'(Mem_Write), 32'd0);
    checkOutput("abort_state", 32'(state), 32'd0);
    checkOutput("abort_ctrl", 32'(dut_ctl), 32'd0);
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;

    applyStimulus("ill_funct", 6'h00, 6'h01, 0, 0, 1'b0, 1'b0, 0);
    checkOutput("ill_funct_halt", 32'(halt), 32'd1);
    pulseReset("ill_funct_rst");

    applyStimulus("j", 6'h02, 6'h00, 1, 0, 1'b0, 1'b0, 0);
    settle("j", 32'd1);

    applyStimulus("ill_op", 6'h3f, 6'h20, 0, 0, 1'b0, 1'b0, 0);
    checkOutput("ill_op_halt", 32'(halt), 32'd1);
    checkOutput("ill_op_cnt", instr_cnt, 32'd1);
    pulseReset("ill_op_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
